// File: rtl/ext_bus_controller_if.sv
// Core strobe bus and asynchronous SRAM pins of ext_bus_controller, grouped as one port.
interface ext_bus_controller_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic [ADDR_W-1:0] ADDR_BUF;
  logic [DATA_W-1:0] DOUT_BUF;
  logic              RDN_BUF;
  logic              WRN0_BUF;
  logic              WRN1_BUF;
  logic              ABUS_OEN;
  logic [DATA_W-1:0] DIN;
  logic              BUSY;
  logic              ERR;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_DQ_OUT;
  logic [DATA_W-1:0] MEM_DQ_IN;
  logic              MEM_DQ_OE;
  logic              MEM_CEN;
  logic              MEM_OEN;
  logic              MEM_WEN;
  logic              MEM_BLEN;
  logic              MEM_BHEN;

  modport slave (
    input  ADDR_BUF, DOUT_BUF, RDN_BUF, WRN0_BUF, WRN1_BUF, ABUS_OEN, MEM_DQ_IN,
    output DIN, BUSY, ERR, MEM_ADDR, MEM_DQ_OUT, MEM_DQ_OE,
           MEM_CEN, MEM_OEN, MEM_WEN, MEM_BLEN, MEM_BHEN
  );

  modport master (
    output ADDR_BUF, DOUT_BUF, RDN_BUF, WRN0_BUF, WRN1_BUF, ABUS_OEN, MEM_DQ_IN,
    input  DIN, BUSY, ERR, MEM_ADDR, MEM_DQ_OUT, MEM_DQ_OE,
           MEM_CEN, MEM_OEN, MEM_WEN, MEM_BLEN, MEM_BHEN
  );
endinterface

// File: rtl/ext_bus_controller.sv
// Turns core bus strobes into a timed async SRAM cycle (setup, WAIT_STATES strobe, recover).
// Each state decides the pin values for the following cycle, so BUSY spans WAIT_STATES+3 cycles.
module ext_bus_controller #(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  ext_bus_controller_if.slave  bus
);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_e;

  state_e            state_q, state_d;
  logic              rdn_prev_q, rdn_prev_d;
  logic              wrn0_prev_q, wrn0_prev_d;
  logic              wrn1_prev_q, wrn1_prev_d;
  logic              rd_fall_c, wr_fall_c, req_c, accept_c;
  logic              is_wr_q, is_wr_d;
  logic              lane_lo_q, lane_lo_d;
  logic              lane_hi_q, lane_hi_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_dq_out_q, mem_dq_out_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              dq_oe_q, dq_oe_d;
  logic              cen_q, cen_d;
  logic              oen_q, oen_d;
  logic              wen_q, wen_d;
  logic              blen_q, blen_d;
  logic              bhen_q, bhen_d;

  // Falling-edge detect against last cycle's sample; ABUS_OEN high masks requests.
  always_comb begin
    rd_fall_c = rdn_prev_q & ~bus.RDN_BUF;
    wr_fall_c = (wrn0_prev_q & ~bus.WRN0_BUF) | (wrn1_prev_q & ~bus.WRN1_BUF);
    req_c     = (rd_fall_c | wr_fall_c) & ~bus.ABUS_OEN;
    accept_c  = req_c & ~busy_q;
  end

  always_comb begin
    state_d      = state_q;
    rdn_prev_d   = bus.RDN_BUF;
    wrn0_prev_d  = bus.WRN0_BUF;
    wrn1_prev_d  = bus.WRN1_BUF;
    is_wr_d      = is_wr_q;
    lane_lo_d    = lane_lo_q;
    lane_hi_d    = lane_hi_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_dq_out_d = mem_dq_out_q;
    din_d        = din_q;
    busy_d       = busy_q;
    dq_oe_d      = dq_oe_q;
    cen_d        = cen_q;
    oen_d        = oen_q;
    wen_d        = wen_q;
    blen_d       = blen_q;
    bhen_d       = bhen_q;
    // A request while busy, or read and write falling together, is a protocol error.
    err_d        = req_c & (busy_q | (rd_fall_c & wr_fall_c));

    unique case (state_q)
      IDLE: begin
        if (busy_q) begin
          busy_d = 1'b0;
        end else if (accept_c) begin
          mem_addr_d   = bus.ADDR_BUF;
          mem_dq_out_d = bus.DOUT_BUF;
          is_wr_d      = wr_fall_c;
          lane_lo_d    = ~wr_fall_c | ~bus.WRN0_BUF;
          lane_hi_d    = ~wr_fall_c | ~bus.WRN1_BUF;
          busy_d       = 1'b1;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        cen_d   = 1'b0;
        blen_d  = ~lane_lo_q;
        bhen_d  = ~lane_hi_q;
        dq_oe_d = is_wr_q;
        cnt_d   = CNT_W'(WAIT_STATES - 1);
        state_d = STROBE;
      end
      STROBE: begin
        oen_d = is_wr_q;
        wen_d = ~is_wr_q;
        if (cnt_q == '0) begin
          state_d = RECOVER;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RECOVER: begin
        // Read data is sampled on the edge that releases MEM_OEN.
        if (!is_wr_q) begin
          din_d = bus.MEM_DQ_IN;
        end
        oen_d   = 1'b1;
        wen_d   = 1'b1;
        cen_d   = 1'b1;
        blen_d  = 1'b1;
        bhen_d  = 1'b1;
        dq_oe_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      rdn_prev_q   <= 1'b1;
      wrn0_prev_q  <= 1'b1;
      wrn1_prev_q  <= 1'b1;
      is_wr_q      <= 1'b0;
      lane_lo_q    <= 1'b0;
      lane_hi_q    <= 1'b0;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_dq_out_q <= '0;
      din_q        <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      dq_oe_q      <= 1'b0;
      cen_q        <= 1'b1;
      oen_q        <= 1'b1;
      wen_q        <= 1'b1;
      blen_q       <= 1'b1;
      bhen_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      rdn_prev_q   <= rdn_prev_d;
      wrn0_prev_q  <= wrn0_prev_d;
      wrn1_prev_q  <= wrn1_prev_d;
      is_wr_q      <= is_wr_d;
      lane_lo_q    <= lane_lo_d;
      lane_hi_q    <= lane_hi_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_dq_out_q <= mem_dq_out_d;
      din_q        <= din_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      dq_oe_q      <= dq_oe_d;
      cen_q        <= cen_d;
      oen_q        <= oen_d;
      wen_q        <= wen_d;
      blen_q       <= blen_d;
      bhen_q       <= bhen_d;
    end
  end

  assign bus.DIN        = din_q;
  assign bus.BUSY       = busy_q;
  assign bus.ERR        = err_q;
  assign bus.MEM_ADDR   = mem_addr_q;
  assign bus.MEM_DQ_OUT = mem_dq_out_q;
  assign bus.MEM_DQ_OE  = dq_oe_q;
  assign bus.MEM_CEN    = cen_q;
  assign bus.MEM_OEN    = oen_q;
  assign bus.MEM_WEN    = wen_q;
  assign bus.MEM_BLEN   = blen_q;
  assign bus.MEM_BHEN   = bhen_q;

endmodule

// File: tb/tb_ext_bus_controller.sv
// Directed vector-table bench for ext_bus_controller (WAIT_STATES=2) plus a WAIT_STATES=1 instance.
module tb_ext_bus_controller;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  // ctrl = {BUSY, MEM_CEN, MEM_OEN, MEM_WEN, MEM_BLEN, MEM_BHEN, MEM_DQ_OE, ERR}
  localparam logic [7:0] C_IDLE = 8'b0111_1100;
  localparam logic [7:0] C_BUSY = 8'b1111_1100;

  typedef struct {
    logic [3:0]  in;     // {RDN, WRN0, WRN1, ABUS_OEN}
    logic [15:0] addr;
    logic [15:0] dout;
    logic [15:0] dqin;
    logic [7:0]  ctrl;
    logic [15:0] din;
    logic [15:0] maddr;
    logic [15:0] dqo;
  } row_t;

  logic CLK = 1'b0;
  logic RESET;
  int   total = 0;
  int   bad   = 0;
  row_t  tbl[$];
  string tags[$];
  int    split;

  ext_bus_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus2 ();
  ext_bus_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

  ext_bus_controller #(.WAIT_STATES(2), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut2 (
    .CLK(CLK), .RESET(RESET), .bus(bus2)
  );
  ext_bus_controller #(.WAIT_STATES(1), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut1 (
    .CLK(CLK), .RESET(RESET), .bus(bus1)
  );

  always #5 CLK = ~CLK;

  task automatic add(input string tag, input logic [3:0] in, input logic [15:0] a,
                     input logic [15:0] d, input logic [15:0] q, input logic [7:0] c,
                     input logic [15:0] di, input logic [15:0] ma, input logic [15:0] mq);
    row_t r;
    r.in = in; r.addr = a; r.dout = d; r.dqin = q;
    r.ctrl = c; r.din = di; r.maddr = ma; r.dqo = mq;
    tbl.push_back(r);
    tags.push_back(tag);
  endtask

  task automatic drive2(input logic [3:0] in, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] q);
    bus2.RDN_BUF  = in[3];
    bus2.WRN0_BUF = in[2];
    bus2.WRN1_BUF = in[1];
    bus2.ABUS_OEN = in[0];
    bus2.ADDR_BUF = a;
    bus2.DOUT_BUF = d;
    bus2.MEM_DQ_IN = q;
  endtask

  task automatic drive1(input logic [3:0] in, input logic [15:0] a, input logic [15:0] q);
    bus1.RDN_BUF  = in[3];
    bus1.WRN0_BUF = in[2];
    bus1.WRN1_BUF = in[1];
    bus1.ABUS_OEN = in[0];
    bus1.ADDR_BUF = a;
    bus1.DOUT_BUF = 16'h0000;
    bus1.MEM_DQ_IN = q;
  endtask

  task automatic check2(input string tag, input int idx, input logic [7:0] c,
                        input logic [15:0] di, input logic [15:0] ma, input logic [15:0] mq);
    logic [7:0] got;
    got = {bus2.BUSY, bus2.MEM_CEN, bus2.MEM_OEN, bus2.MEM_WEN,
           bus2.MEM_BLEN, bus2.MEM_BHEN, bus2.MEM_DQ_OE, bus2.ERR};
    total++;
    if (got !== c || bus2.DIN !== di || bus2.MEM_ADDR !== ma || bus2.MEM_DQ_OUT !== mq) begin
      bad++;
      $display("FAIL %s[%0d]: got ctrl=%b din=%h addr=%h dq=%h, want ctrl=%b din=%h addr=%h dq=%h",
               tag, idx, got, bus2.DIN, bus2.MEM_ADDR, bus2.MEM_DQ_OUT, c, di, ma, mq);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d (0x%h), want %0d (0x%h)", name, got, got, want, want);
    end
  endtask

  task automatic apply_row(input int i);
    drive2(tbl[i].in, tbl[i].addr, tbl[i].dout, tbl[i].dqin);
    @(posedge CLK);
    @(negedge CLK);
    check2(tags[i], i, tbl[i].ctrl, tbl[i].din, tbl[i].maddr, tbl[i].dqo);
  endtask

  initial begin
    int n_oen, n_wen, n_busy, n_cen;

    for (int k = 0; k < 5; k++) add("idle", 4'b1110, 16'h0000, 16'h0000, 16'h0000, C_IDLE, 16'h0000, 16'h0000, 16'h0000);
    add("read",  4'b0110, 16'h0004, 16'h0000, 16'hFAAF, C_BUSY,       16'h0000, 16'h0004, 16'h0000);
    add("read",  4'b0110, 16'h0004, 16'h0000, 16'hFAAF, 8'b1011_0000, 16'h0000, 16'h0004, 16'h0000);
    add("read",  4'b0110, 16'h0004, 16'h0000, 16'hFAAF, 8'b1001_0000, 16'h0000, 16'h0004, 16'h0000);
    add("read",  4'b0110, 16'h0004, 16'h0000, 16'hFAAF, 8'b1001_0000, 16'h0000, 16'h0004, 16'h0000);
    add("read",  4'b0110, 16'h0004, 16'h0000, 16'hFAAF, C_BUSY,       16'hFAAF, 16'h0004, 16'h0000);
    add("read",  4'b0110, 16'h0004, 16'h0000, 16'hFAAF, C_IDLE,       16'hFAAF, 16'h0004, 16'h0000);
    add("hold",  4'b0110, 16'h0004, 16'h0000, 16'h0000, C_IDLE,       16'hFAAF, 16'h0004, 16'h0000);
    add("hold",  4'b0110, 16'h0004, 16'h0000, 16'h0000, C_IDLE,       16'hFAAF, 16'h0004, 16'h0000);
    add("hold",  4'b1110, 16'h0004, 16'h0000, 16'h0000, C_IDLE,       16'hFAAF, 16'h0004, 16'h0000);
    add("bwr",   4'b1010, 16'h0010, 16'h12AF, 16'h5555, C_BUSY,       16'hFAAF, 16'h0010, 16'h12AF);
    add("bwr",   4'b1010, 16'h0010, 16'h12AF, 16'h5555, 8'b1011_0110, 16'hFAAF, 16'h0010, 16'h12AF);
    add("bwr",   4'b1010, 16'h0010, 16'h12AF, 16'h5555, 8'b1010_0110, 16'hFAAF, 16'h0010, 16'h12AF);
    add("bwr",   4'b1010, 16'h0010, 16'h12AF, 16'h5555, 8'b1010_0110, 16'hFAAF, 16'h0010, 16'h12AF);
    add("bwr",   4'b1010, 16'h0010, 16'h12AF, 16'h5555, C_BUSY,       16'hFAAF, 16'h0010, 16'h12AF);
    add("bwr",   4'b1010, 16'h0010, 16'h12AF, 16'h5555, C_IDLE,       16'hFAAF, 16'h0010, 16'h12AF);
    add("bwr",   4'b1110, 16'h0010, 16'h12AF, 16'h5555, C_IDLE,       16'hFAAF, 16'h0010, 16'h12AF);
    add("confl", 4'b0100, 16'h0030, 16'hBEEF, 16'h5555, 8'b1111_1101, 16'hFAAF, 16'h0030, 16'hBEEF);
    add("confl", 4'b0100, 16'h0030, 16'hBEEF, 16'h5555, 8'b1011_1010, 16'hFAAF, 16'h0030, 16'hBEEF);
    add("confl", 4'b0100, 16'h0030, 16'hBEEF, 16'h5555, 8'b1010_1010, 16'hFAAF, 16'h0030, 16'hBEEF);
    add("confl", 4'b0100, 16'h0030, 16'hBEEF, 16'h5555, 8'b1010_1010, 16'hFAAF, 16'h0030, 16'hBEEF);
    add("confl", 4'b0100, 16'h0030, 16'hBEEF, 16'h5555, C_BUSY,       16'hFAAF, 16'h0030, 16'hBEEF);
    add("confl", 4'b0100, 16'h0030, 16'hBEEF, 16'h5555, C_IDLE,       16'hFAAF, 16'h0030, 16'hBEEF);
    add("confl", 4'b1110, 16'h0030, 16'hBEEF, 16'h5555, C_IDLE,       16'hFAAF, 16'h0030, 16'hBEEF);
    add("ovl",   4'b0110, 16'h0040, 16'h0000, 16'h1234, C_BUSY,       16'hFAAF, 16'h0040, 16'h0000);
    add("ovl",   4'b1110, 16'h0040, 16'h0000, 16'h1234, 8'b1011_0000, 16'hFAAF, 16'h0040, 16'h0000);
    add("ovl",   4'b0110, 16'h0044, 16'h0000, 16'h1234, 8'b1001_0001, 16'hFAAF, 16'h0040, 16'h0000);
    add("ovl",   4'b0110, 16'h0044, 16'h0000, 16'h1234, 8'b1001_0000, 16'hFAAF, 16'h0040, 16'h0000);
    add("ovl",   4'b0110, 16'h0044, 16'h0000, 16'h1234, C_BUSY,       16'h1234, 16'h0040, 16'h0000);
    add("ovl",   4'b0110, 16'h0044, 16'h0000, 16'h1234, C_IDLE,       16'h1234, 16'h0040, 16'h0000);
    add("ovl",   4'b0110, 16'h0044, 16'h0000, 16'h1234, C_IDLE,       16'h1234, 16'h0040, 16'h0000);
    add("ovl",   4'b1110, 16'h0044, 16'h0000, 16'h1234, C_IDLE,       16'h1234, 16'h0040, 16'h0000);
    add("gate",  4'b0111, 16'h00EE, 16'h0000, 16'h0000, C_IDLE,       16'h1234, 16'h0040, 16'h0000);
    add("gate",  4'b0110, 16'h00EE, 16'h0000, 16'h0000, C_IDLE,       16'h1234, 16'h0040, 16'h0000);
    add("gate",  4'b1110, 16'h00EE, 16'h0000, 16'h0000, C_IDLE,       16'h1234, 16'h0040, 16'h0000);
    add("midrst",4'b1000, 16'h0050, 16'h7777, 16'h0000, C_BUSY,       16'h1234, 16'h0050, 16'h7777);
    add("midrst",4'b1000, 16'h0050, 16'h7777, 16'h0000, 8'b1011_0010, 16'h1234, 16'h0050, 16'h7777);
    add("midrst",4'b1000, 16'h0050, 16'h7777, 16'h0000, 8'b1010_0010, 16'h1234, 16'h0050, 16'h7777);
    split = tbl.size();
    add("post",  4'b1110, 16'h0000, 16'h0000, 16'h0000, C_IDLE,       16'h0000, 16'h0000, 16'h0000);
    add("post",  4'b0110, 16'h0020, 16'h0000, 16'hABCD, C_BUSY,       16'h0000, 16'h0020, 16'h0000);
    add("post",  4'b0110, 16'h0020, 16'h0000, 16'hABCD, 8'b1011_0000, 16'h0000, 16'h0020, 16'h0000);
    add("post",  4'b0110, 16'h0020, 16'h0000, 16'hABCD, 8'b1001_0000, 16'h0000, 16'h0020, 16'h0000);
    add("post",  4'b0110, 16'h0020, 16'h0000, 16'hABCD, 8'b1001_0000, 16'h0000, 16'h0020, 16'h0000);
    add("post",  4'b0110, 16'h0020, 16'h0000, 16'hABCD, C_BUSY,       16'hABCD, 16'h0020, 16'h0000);
    add("post",  4'b0110, 16'h0020, 16'h0000, 16'hABCD, C_IDLE,       16'hABCD, 16'h0020, 16'h0000);
    add("post",  4'b1110, 16'h0020, 16'h0000, 16'hABCD, C_IDLE,       16'hABCD, 16'h0020, 16'h0000);

    RESET = 1'b1;
    drive2(4'b1110, 16'h0000, 16'h0000, 16'h0000);
    drive1(4'b1110, 16'h0000, 16'h0000);
    #1;
    check2("reset", 0, C_IDLE, 16'h0000, 16'h0000, 16'h0000);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < split; i++) apply_row(i);

    // Abort the write while MEM_WEN is low: pins must release before the next edge.
    #2;
    RESET = 1'b1;
    drive2(4'b1110, 16'h0000, 16'h0000, 16'h0000);
    #1;
    check2("midrst_async", 0, C_IDLE, 16'h0000, 16'h0000, 16'h0000);
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = split; i < tbl.size(); i++) apply_row(i);

    // Single wait state: one strobe cycle, four BUSY cycles.
    n_oen = 0; n_wen = 0; n_busy = 0; n_cen = 0;
    drive1(4'b0110, 16'h0060, 16'h0F0F);
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (!bus1.MEM_OEN) n_oen++;
      if (!bus1.MEM_WEN) n_wen++;
      if (!bus1.MEM_CEN) n_cen++;
      if (bus1.BUSY)     n_busy++;
    end
    drive1(4'b1110, 16'h0060, 16'h0000);
    check_val("ws1_oen_cycles", n_oen, 1);
    check_val("ws1_wen_cycles", n_wen, 0);
    check_val("ws1_cen_cycles", n_cen, 2);
    check_val("ws1_busy_cycles", n_busy, 4);
    check_val("ws1_din", int'(bus1.DIN), 32'h0F0F);
    check_val("ws1_addr", int'(bus1.MEM_ADDR), 32'h0060);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ext_bus_controller.md
Name: ext_bus_controller

Overview:
- Sits directly downstream of `core` on the external bus.
- Consumes the core's bus strobes (RDN_BUF, WRN0_BUF, WRN1_BUF, ABUS_OEN) and turns them into a timed asynchronous SRAM cycle with a programmable number of wait states.
- On reads, returns latched read data to the core's DIN.
- Raises BUSY so the core's phase sequencer can stretch EXECUTE/COMMIT until the cycle completes.

Parameters:
- WAIT_STATES, 2, number of CLK cycles the SRAM strobe is held low (legal range 1..15).
- ADDR_W, 16, address width.
- DATA_W, 16, data width; byte lanes are DATA_W/2.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ADDR_BUF  input  ADDR_W  core address.
- DOUT_BUF  input  DATA_W  core write data.
- RDN_BUF  input  1  core read strobe, active low.
- WRN0_BUF  input  1  core low-byte write strobe, active low.
- WRN1_BUF  input  1  core high-byte write strobe, active low.
- ABUS_OEN  input  1  core address-bus enable, active low; requests are ignored while high.
- DIN  output  DATA_W  read data to core, held until the next read completes.
- BUSY  output  1  high while a bus cycle is in progress.
- ERR  output  1  one-cycle pulse on a protocol violation.
- MEM_ADDR  output  ADDR_W  registered SRAM address.
- MEM_DQ_OUT  output  DATA_W  registered SRAM write data.
- MEM_DQ_IN  input  DATA_W  SRAM read data.
- MEM_DQ_OE  output  1  drive enable for MEM_DQ_OUT, active high.
- MEM_CEN  output  1  SRAM chip enable, active low.
- MEM_OEN  output  1  SRAM output enable, active low.
- MEM_WEN  output  1  SRAM write enable, active low.
- MEM_BLEN  output  1  low byte enable, active low.
- MEM_BHEN  output  1  high byte enable, active low.

Behaviour:
- Reset values (asynchronous, immediate):
  - state=IDLE, DIN=0, BUSY=0, ERR=0, MEM_ADDR=0, MEM_DQ_OUT=0, MEM_DQ_OE=0.
  - MEM_CEN, MEM_OEN, MEM_WEN, MEM_BLEN, MEM_BHEN all =1.
  - RESET asserted mid-cycle aborts the cycle: strobes deassert in the same instant, no write completes, DIN is cleared.
- Request detection:
  - Strobes are registered once (prev-sample register, reset to 1).
  - A request is a falling edge on RDN_BUF, or on either WRN, while ABUS_OEN=0 and state=IDLE.
  - Levels held low after completion do not retrigger; the strobe must return high first.
- Conflict: RDN and any WRN both falling in the same cycle → write is performed, ERR pulses 1 cycle.
- Requests arriving while BUSY=1 are ignored and pulse ERR.
- FSM states: IDLE → SETUP → STROBE → RECOVER → IDLE.
- IDLE, on request:
  - Latch ADDR_BUF→MEM_ADDR and DOUT_BUF→MEM_DQ_OUT.
  - Latch the byte lanes: WRN0 low→BLEN low, WRN1 low→BHEN low; a read enables both lanes.
  - BUSY=1, go to SETUP.
- SETUP (1 cycle):
  - MEM_CEN=0.
  - On a write, MEM_DQ_OE=1.
  - Load the wait counter with WAIT_STATES-1, go to STROBE.
- STROBE:
  - Read: MEM_OEN=0. Write: MEM_WEN=0.
  - Counter decrements each cycle. When the counter=0:
    - On a read, capture MEM_DQ_IN into DIN.
    - Deassert MEM_OEN/MEM_WEN and go to RECOVER.
  - Strobe width is exactly WAIT_STATES cycles.
- RECOVER (1 cycle):
  - MEM_CEN=1, MEM_DQ_OE=0, byte enables=1.
  - Address and data are held through this cycle (hold time).
  - BUSY=0 at the exit edge; return to IDLE.
- Total BUSY duration = WAIT_STATES+3 cycles, measured from the request-detect edge to BUSY falling.
- Write with neither lane enabled cannot occur; a read never drives MEM_DQ_OE.
- WAIT_STATES=1 gives a single-cycle strobe; the counter must not underflow or wrap.

Test Plan:
- Reset: RESET=1 at t0 → all MEM_* strobes 1, BUSY=0, DIN=0; release RESET, 5 idle cycles → no strobe activity.
- Read, WAIT_STATES=2: ADDR_BUF=0x0004, ABUS_OEN=0, RDN_BUF falls, MEM_DQ_IN=0xFAAF → MEM_OEN low exactly 2 cycles, both byte enables low; DIN=0xFAAF after STROBE; BUSY high 5 cycles; MEM_WEN stays 1.
- Byte write: ADDR_BUF=0x0010, DOUT_BUF=0x12AF, only WRN0_BUF falls → MEM_BLEN=0, MEM_BHEN=1, MEM_WEN low 2 cycles, MEM_DQ_OE high from SETUP through STROBE, MEM_DQ_OUT=0x12AF; DIN unchanged.
- Conflict and overlap:
  - RDN_BUF and WRN1_BUF fall together → write cycle with BHEN=0, ERR 1-cycle pulse.
  - New RDN edge during BUSY → ignored, ERR pulse, no second cycle.
- Reset mid-write: assert RESET during STROBE → MEM_WEN and MEM_CEN go 1 asynchronously, BUSY=0; after release, a subsequent read to 0x0020 completes normally.
- Gating and boundary:
  - ABUS_OEN=1 with RDN_BUF falling → no cycle.
  - WAIT_STATES=1 → 1-cycle strobe, BUSY 4 cycles.
  - RDN_BUF held low after completion → no retrigger.
